// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit:
// FSM state enum, opcode values, ALU control codes and alu_op encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWRITE,
        MEMWB,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        JAL,
        BEQ,
        ILLEGAL
    } state_t;

    localparam state_t RESET_STATE = FETCH;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_BAD = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Immediate format follows the opcode alone, in every state.
    function automatic logic [1:0] imm_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = 2'b00;
        if (op == OP_SW)  imm = 2'b01;
        if (op == OP_BR)  imm = 2'b10;
        if (op == OP_JAL) imm = 2'b11;
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: alu_op/funct3/op[5]/funct7b5 -> 3-bit alu_ctrl.
// bad_funct flags an unsupported funct3 regardless of alu_op.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl,
    output logic       bad_funct
);

    logic [2:0] funct_ctrl;

    always_comb begin
        bad_funct  = 1'b0;
        funct_ctrl = ALU_ADD;
        unique case (funct3)
            3'b000:  funct_ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b100:  funct_ctrl = ALU_XOR;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: begin
                funct_ctrl = ALU_BAD;
                bad_funct  = 1'b1;
            end
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_BAD;
        unique case (alu_op)
            ALUOP_ADD:   alu_ctrl = ALU_ADD;
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: alu_ctrl = funct_ctrl;
            default:     alu_ctrl = ALU_BAD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM driving datapath selects/enables and alu_ctrl.
// Ports: clk, reset (async high), op/funct3/funct7b5/zero in; pc_write,
// adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_ctrl,
// imm_src, reg_write, illegal_op out. Optional macro: MC_CTRL_BNE_EN (bne).
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op
);

    state_t  state, state_nx;
    alu_op_t alu_op;
    logic    bad_funct;
    logic    br_ok;
    logic    br_take;

    alu_decoder u_alu_decoder (
        .alu_op    (alu_op),
        .funct3    (funct3),
        .op5       (op[5]),
        .funct7b5  (funct7b5),
        .alu_ctrl  (alu_ctrl),
        .bad_funct (bad_funct)
    );

`ifdef MC_CTRL_BNE_EN
    assign br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign br_take = funct3[0] ? ~zero : zero;
`else
    assign br_ok   = (funct3 == 3'b000);
    assign br_take = zero;
`endif

    assign imm_src = imm_of(op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        unique case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_nx   = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_R: begin
                        state_nx   = EXECUTER;
                        illegal_op = bad_funct;
                    end
                    OP_I: begin
                        state_nx   = EXECUTEI;
                        illegal_op = bad_funct;
                    end
                    OP_JAL: state_nx = JAL;
                    // Unsupported branch funct3 still runs BEQ, never taken.
                    OP_BR: begin
                        state_nx   = BEQ;
                        illegal_op = ~br_ok;
                    end
                    default: begin
                        state_nx   = ILLEGAL;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_SW) state_nx = MEMWRITE;
                else             state_nx = MEMREAD;
            end
            MEMREAD: begin
                adr_src  = 1'b1;
                state_nx = MEMWB;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_nx  = FETCH;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nx   = FETCH;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
                state_nx  = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
                state_nx  = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_nx  = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_nx  = ALUWB;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                pc_write  = br_ok & br_take;
                state_nx  = FETCH;
            end
            ILLEGAL: begin
                if (ILLEGAL_TRAP) state_nx = ILLEGAL;
                else              state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit against an instruction-level model.
// A second instance with ILLEGAL_TRAP=1 covers the trap behaviour.
module tb_mc_control_unit;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BR  = 7'b1100011;

`ifdef MC_CTRL_BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3;
    localparam int K_JAL = 4, K_BR = 5, K_BAD = 6;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4;
    localparam int P_MWB = 5, P_XR = 6, P_XI = 7, P_AW = 8;
    localparam int P_J = 9, P_B = 10, P_IL = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_t = 1'b1;
    logic [6:0] op = LW;
    logic [2:0] funct3 = 3'b000;
    logic funct7b5 = 1'b0;
    logic zero = 1'b0;

    logic pcw_m, adr_m, memw_m, irw_m, rw_m, ill_m;
    logic [1:0] rs_m, sa_m, sb_m, imm_m;
    logic [2:0] ac_m;
    logic pcw_t, adr_t, memw_t, irw_t, rw_t, ill_t;
    logic [1:0] rs_t, sa_t, sb_t, imm_t;
    logic [2:0] ac_t;

    logic [18:0] got_m, got_t;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pcw_m),
        .adr_src(adr_m), .mem_write(memw_m), .ir_write(irw_m),
        .result_src(rs_m), .alu_src_a(sa_m), .alu_src_b(sb_m),
        .alu_ctrl(ac_m), .imm_src(imm_m), .reg_write(rw_m),
        .illegal_op(ill_m)
    );

    mc_control_unit #(.ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset(rst_t), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pcw_t),
        .adr_src(adr_t), .mem_write(memw_t), .ir_write(irw_t),
        .result_src(rs_t), .alu_src_a(sa_t), .alu_src_b(sb_t),
        .alu_ctrl(ac_t), .imm_src(imm_t), .reg_write(rw_t),
        .illegal_op(ill_t)
    );

    assign got_m = {pcw_m, adr_m, memw_m, irw_m, rs_m, sa_m, sb_m,
                    ac_m, imm_m, rw_m, ill_m};
    assign got_t = {pcw_t, adr_t, memw_t, irw_t, rs_t, sa_t, sb_t,
                    ac_t, imm_t, rw_t, ill_t};

    task automatic chk(input string tag, input logic [18:0] got,
                       input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    function automatic int len_of(input int kind);
        case (kind)
            K_LW:    return 5;
            K_SW, K_R, K_I, K_JAL: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int phase_of(input int kind, input int step);
        if (step == 0) return P_F;
        if (step == 1) return P_D;
        case (kind)
            K_LW:    return step == 2 ? P_MA : (step == 3 ? P_MR : P_MWB);
            K_SW:    return step == 2 ? P_MA : P_MW;
            K_R:     return step == 2 ? P_XR : P_AW;
            K_I:     return step == 2 ? P_XI : P_AW;
            K_JAL:   return step == 2 ? P_J : P_AW;
            K_BR:    return P_B;
            default: return P_IL;
        endcase
    endfunction

    // ALU operation requested by an R/I instruction's funct fields.
    function automatic logic [2:0] op_code(input logic o5,
                                           input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'd0:    return (o5 && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd4:    return 3'd4;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic is_bad(input int kind, input logic [2:0] f3);
        if (kind == K_BAD) return 1'b1;
        if (kind == K_R || kind == K_I)
            return f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5;
        if (kind == K_BR)
            return !(f3 == 3'd0 || (BNE && f3 == 3'd1));
        return 1'b0;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z);
        if (f3 == 3'd0) return z;
        if (BNE && f3 == 3'd1) return !z;
        return 1'b0;
    endfunction

    function automatic logic [18:0] exp_vec(input int kind, input int step,
                                            input logic [6:0] o,
                                            input logic [2:0] f3,
                                            input logic f7, input logic z);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; ac = 0;
        imm = (o == SW) ? 2'd1 : (o == BR) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        case (phase_of(kind, step))
            P_F:   begin pcw = 1; irw = 1; rs = 2; sb = 2; end
            P_D:   begin sa = 1; sb = 1; ill = is_bad(kind, f3); end
            P_MA:  begin sa = 2; sb = 1; end
            P_MR:  adr = 1;
            P_MW:  begin adr = 1; mw = 1; end
            P_MWB: begin rs = 1; rw = 1; end
            P_XR:  begin sa = 2; sb = 0; ac = op_code(o[5], f3, f7); end
            P_XI:  begin sa = 2; sb = 1; ac = op_code(o[5], f3, f7); end
            P_AW:  rw = 1;
            P_J:   begin pcw = 1; sa = 1; sb = 2; end
            P_B:   begin pcw = taken(f3, z); sa = 2; ac = 3'd1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ill};
    endfunction

    // Entered and left at posedge+1 with the DUT in FETCH.
    task automatic run(input int kind, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7,
                       input int zmode, input int nsteps,
                       input string tag);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int s = 0; s < nsteps; s++) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            chk($sformatf("%s.s%0d", tag, s), got_m,
                exp_vec(kind, s, o, f3, f7, zero));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_rand(input int idx);
        int kind;
        logic [6:0] o;
        logic [2:0] f3;
        kind = $urandom_range(0, 6);
        f3 = 3'($urandom_range(0, 7));
        case (kind)
            K_LW:  o = LW;
            K_SW:  o = SW;
            K_R:   o = RT;
            K_I:   o = IT;
            K_JAL: o = JL;
            K_BR:  begin o = BR; f3 = 3'($urandom_range(0, 3)); end
            default: begin
                o = 7'($urandom_range(0, 127));
                while (o == LW || o == SW || o == RT || o == IT ||
                       o == JL || o == BR)
                    o = 7'($urandom_range(0, 127));
            end
        endcase
        run(kind, o, f3, 1'($urandom_range(0, 1)), -1, len_of(kind),
            $sformatf("rnd%0d.k%0d", idx, kind));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        rst_t = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(tag, got_m, exp_vec(K_LW, 0, op, funct3, funct7b5, zero));
        reset = 1'b0;
    endtask

    initial begin
        op = LW;
        do_reset("reset");

        rst_t = 1'b0;
        op = 7'b1111111; funct3 = 3'd0; funct7b5 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("trap.s%0d", k), got_t,
                exp_vec(K_BAD, k < 2 ? k : 2, op, funct3, funct7b5, zero));
            @(posedge clk);
            #1;
        end
        rst_t = 1'b1;
        #1;
        chk("trap_rst", got_t, exp_vec(K_BAD, 0, op, funct3, funct7b5, zero));
        do_reset("reset2");

        run(K_R, RT, 3'd0, 1'b1, -1, 4, "sub");
        run(K_LW, LW, 3'd2, 1'b0, -1, 5, "lw");
        run(K_SW, SW, 3'd2, 1'b0, -1, 4, "sw");
        run(K_BR, BR, 3'd0, 1'b0, 1, 3, "beq_z1");
        run(K_BR, BR, 3'd0, 1'b0, 0, 3, "beq_z0");
        run(K_BAD, 7'b1111111, 3'd0, 1'b0, -1, 3, "bad_op");
        run(K_I, IT, 3'd3, 1'b0, -1, 4, "i_f3_011");
        run(K_JAL, JL, 3'd0, 1'b0, -1, 4, "jal");
        run(K_BR, BR, 3'd1, 1'b0, 0, 3, "bne_z0");
        run(K_BR, BR, 3'd1, 1'b0, 1, 3, "bne_z1");

        run(K_LW, LW, 3'd2, 1'b0, -1, 3, "lw_cut");
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async", got_m, exp_vec(K_LW, 0, LW, 3'd2, 1'b0, zero));
        reset = 1'b0;
        run(K_LW, LW, 3'd2, 1'b0, -1, 5, "lw_after_rst");

        for (int i = 0; i < 80; i++) run_rand(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
